// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, clocks-per-bit derivation and frame constants.
// Used by both the transmitter and the receiver so the two agree on timing.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Clocks per line bit; integer division, valid range 2..65535.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Even parity over one data byte: 1 when the byte holds an odd number of ones.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// 16-bit clocks-per-bit counter with enable and synchronous clear; bit_end
// pulses for one clock on the last count of each bit period.
module uart_baud_cnt #(
    parameter int unsigned DIVIDOR = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic bit_end
);

    localparam logic [15:0] LAST_CNT = 16'(DIVIDOR - 32'd1);

    logic [15:0] cnt_r;

    // Count 0..DIVIDOR-1 while enabled, wrapping back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else if (clr) begin
            cnt_r <= 16'd0;
        end else if (en) begin
            if (cnt_r == LAST_CNT) begin
                cnt_r <= 16'd0;
            end else begin
                cnt_r <= cnt_r + 16'd1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bit_end = en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to add the even-parity bit (frame grows from 10 to 11 bit times).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 48000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy
);

    localparam int unsigned BAUD_DIVIDOR = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [2:0]  LAST_BIT     = 3'(UART_DATA_BITS - 1);

    uart_state_t state_r, state_s;
    logic [7:0]  shift_r, shift_s;
    logic [2:0]  bit_cnt_r, bit_cnt_s;
    logic        txd_r, txd_s;
    logic        ready_r;
    logic        busy_r;
    logic        bit_end_s;
    logic        accept_s;
`ifdef UART_TX_PARITY_EN
    logic        parity_r;
`endif

    assign accept_s = tx_valid && ready_r;

    uart_baud_cnt #(
        .DIVIDOR (BAUD_DIVIDOR)
    ) u_baud_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state_r != ST_IDLE),
        .clr     (state_r == ST_IDLE),
        .bit_end (bit_end_s)
    );

    // Next-state, shift register and line level; txd is derived from the next
    // state so the registered line already shows the start bit at acceptance.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        txd_s     = UART_IDLE_LEVEL;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s   = ST_START;
                    shift_s   = tx_data;
                    bit_cnt_s = 3'd0;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_s   = {1'b0, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        case (state_s)
            ST_IDLE:   txd_s = UART_IDLE_LEVEL;
            ST_START:  txd_s = 1'b0;
            ST_DATA:   txd_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_s = parity_r;
`endif
            ST_STOP:   txd_s = 1'b1;
            default:   txd_s = UART_IDLE_LEVEL;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
            txd_r     <= UART_IDLE_LEVEL;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            txd_r     <= txd_s;
            ready_r   <= (state_s == ST_IDLE);
            busy_r    <= (state_s != ST_IDLE);
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte at acceptance, since shifting destroys it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_r <= 1'b0;
        end else if (accept_s) begin
            parity_r <= even_parity(tx_data);
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

    assign txd      = txd_r;
    assign tx_ready = ready_r;
    assign tx_busy  = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: every clock of each frame is compared with a
// frame built from the byte; honours UART_TX_PARITY_EN.
module tb_uart_tx;

    localparam int D = 48000 / 9600;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int NBITS  = 11;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int NBITS  = 10;
`endif
    localparam int F = NBITS * D;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       tx_busy;

    int n_checks;
    int n_pass;
    logic par_seen;

    uart_tx #(
        .CLK_FREQ (48000),
        .BAUD     (9600)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txd      (txd),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level of bit slot idx of the frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        logic [7:0] tmp;
        int ones;
        ones = 0;
        for (int k = 0; k < 8; k++) begin
            tmp = b >> k;
            ones += int'(tmp[0]);
        end
        if (idx == 0) return 1'b0;
        if (idx <= 8) begin
            tmp = b >> (idx - 1);
            return tmp[0];
        end
        if (idx == 9 && PAR_EN) return (ones % 2) == 1;
        return 1'b1;
    endfunction

    // Caller sets tx_data/tx_valid at a negedge while idle. mode 0: drop valid
    // after acceptance; 1: disturb inputs during frame; 2: hold valid, queue nxt.
    task automatic run_frame(input logic [7:0] b, input int mode, input logic [7:0] nxt,
                             output logic par_out);
        logic [7:0] dec;
        logic       exp_bit;
        int         idx;
        dec     = 8'h00;
        par_out = 1'b0;
        n_checks++;
        if (tx_ready !== 1'b1) $display("FAIL accept_ready: tx_ready=%b expected 1", tx_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        if (mode == 0) tx_valid = 1'b0;
        else if (mode == 2) tx_data = nxt;
        for (int t = 0; t < F; t++) begin
            @(negedge clk);
            exp_bit = frame_bit(b, t / D);
            n_checks++;
            if (txd !== exp_bit || tx_ready !== 1'b0 || tx_busy !== 1'b1)
                $display("FAIL frame_%02h t=%0d: txd,ready,busy=%b%b%b expected %b01",
                         b, t, txd, tx_ready, tx_busy, exp_bit);
            else n_pass++;
            if (t % D == D / 2) begin
                idx = t / D;
                if (idx >= 1 && idx <= 8) dec[idx-1] = txd;
                if (idx == 9) par_out = txd;
            end
            if (mode == 1) begin
                if (t < F - 1) begin
                    tx_valid = 1'($urandom_range(0, 1));
                    tx_data  = 8'hFF;
                end else begin
                    tx_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0)
            $display("FAIL frame_end_%02h: txd,ready,busy=%b%b%b expected 110",
                     b, txd, tx_ready, tx_busy);
        else n_pass++;
        n_checks++;
        if (dec !== b) $display("FAIL decode: got %02h expected %02h", dec, b);
        else n_pass++;
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0)
            $display("FAIL %s: txd,ready,busy=%b%b%b expected 110", name, txd, tx_ready, tx_busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) begin
            @(negedge clk);
            check_idle("reset_hold");
        end
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            check_idle("reset_idle");
        end
    endtask

    task automatic test_single();
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        run_frame(8'hA5, 0, 8'h00, par_seen);
    endtask

    task automatic test_parity();
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        run_frame(8'h07, 0, 8'h00, par_seen);
        if (PAR_EN) begin
            n_checks++;
            if (par_seen !== 1'b1) $display("FAIL parity_07: got %b expected 1", par_seen);
            else n_pass++;
        end
        tx_data  = 8'h03;
        tx_valid = 1'b1;
        run_frame(8'h03, 0, 8'h00, par_seen);
        if (PAR_EN) begin
            n_checks++;
            if (par_seen !== 1'b0) $display("FAIL parity_03: got %b expected 0", par_seen);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int gap;
        for (int i = 0; i < 12; i++) begin
            gap = $urandom_range(0, 6);
            repeat (gap) begin
                @(negedge clk);
                tx_data = 8'($urandom);
                check_idle("random_gap");
            end
            b        = 8'($urandom);
            tx_data  = b;
            tx_valid = 1'b1;
            run_frame(b, 0, 8'h00, par_seen);
        end
    endtask

    task automatic test_back_to_back();
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        run_frame(8'h55, 2, 8'hAA, par_seen);
        run_frame(8'hAA, 0, 8'h00, par_seen);
    endtask

    task automatic test_ignore_busy();
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        run_frame(8'h12, 1, 8'h00, par_seen);
        repeat (2 * F) begin
            @(negedge clk);
            check_idle("no_extra_frame");
        end
    endtask

    task automatic test_reset_mid_frame();
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (4 * D + 2) @(posedge clk);
        #1;
        n_checks++;
        if (txd !== 1'b1 || tx_busy !== 1'b1)
            $display("FAIL mid_bit3: txd,busy=%b%b expected 11", txd, tx_busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        repeat (2) @(negedge clk);
        check_idle("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("after_release");
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        run_frame(8'h81, 0, 8'h00, par_seen);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single();
        test_parity();
        test_random();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
